// File: rtl/math_subtractor_chunked_seq.sv
// Multi-cycle wide subtractor: computes a - b - borrow_in one CHUNK-bit slice per
// cycle through a ripple full-subtractor, registering the borrow between slices.
module math_subtractor_chunked_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_b_in,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_d,
  output logic             o_b
);

  localparam int NUM_CHUNKS = (CHUNK >= 1) ? WIDTH / CHUNK : 1;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

  if (CHUNK < 1) begin : g_bad_chunk
    $fatal(1, "math_subtractor_chunked_seq: CHUNK must be >= 1");
  end else if (WIDTH % CHUNK != 0) begin : g_bad_width
    $fatal(1, "math_subtractor_chunked_seq: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bo_q, bo_d;
  logic             valid_q, valid_d;

  logic [CHUNK-1:0] a_slice, b_slice, slice_diff;
  logic             slice_bo;

  // Select the active slice and push it through a CHUNK-bit ripple subtractor.
  always_comb begin
    logic bw;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    a_slice    = '0;
    b_slice    = '0;
    slice_diff = '0;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        a_slice = a_q[k*CHUNK +: CHUNK];
        b_slice = b_q[k*CHUNK +: CHUNK];
      end
    end
    bw = borrow_q;
    for (int i = 0; i < CHUNK; i++) begin
      slice_diff[i] = a_slice[i] ^ b_slice[i] ^ bw;
      bw = (~a_slice[i] & b_slice[i]) | (~(a_slice[i] ^ b_slice[i]) & bw);
    end
    slice_bo = bw;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    d_d      = d_q;
    bo_d     = bo_q;
    valid_d  = valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          a_d      = i_a;
          b_d      = i_b;
          borrow_d = i_b_in;
          cnt_d    = '0;
          d_d      = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        for (int k = 0; k < NUM_CHUNKS; k++) begin
          if (cnt_q == CNT_W'(k)) d_d[k*CHUNK +: CHUNK] = slice_diff;
        end
        borrow_d = slice_bo;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          bo_d    = slice_bo;
          valid_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (i_rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      d_q      <= '0;
      bo_q     <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      d_q      <= d_d;
      bo_q     <= bo_d;
      valid_q  <= valid_d;
    end
  end

  // Ready is gated by reset so a request can never be accepted on a reset edge.
  assign o_ready = (state_q == S_IDLE) & ~i_rst;
  assign o_valid = valid_q;
  assign o_d     = d_q;
  assign o_b     = bo_q;

endmodule

// File: doc/math_subtractor_chunked_seq.md
Name: math_subtractor_chunked_seq

Overview:
Multi-cycle wide subtractor. It computes a WIDTH-bit a - b - borrow_in by feeding one CHUNK-bit slice per cycle into a CHUNK-bit ripple full-subtractor stage, registering the borrow between slices. It trades latency for area when wide operands (counters, address deltas, credit math) would otherwise need a long combinational borrow chain. Valid/ready handshake on both sides.

Parameters:
WIDTH, 32, total operand/result width in bits.
CHUNK, 8, bits processed per cycle. WIDTH % CHUNK == 0 and CHUNK >= 1 are required, checked at elaboration (fatal on violation).
NUM_CHUNKS, WIDTH/CHUNK, derived (localparam); slices per operation.

Ports:
i_clk  input  1  clock; all state on rising edge.
i_rst  input  1  synchronous, active-high reset.
i_valid  input  1  request valid.
o_ready  output  1  block can accept request; high only in IDLE and not in reset.
i_a  input  WIDTH  minuend.
i_b  input  WIDTH  subtrahend.
i_b_in  input  1  borrow-in to bit 0.
o_valid  output  1  result valid.
i_ready  input  1  downstream accepts result.
o_d  output  WIDTH  difference, registered.
o_b  output  1  final borrow-out, registered.

Behaviour:
- One clock (i_clk); reset i_rst is synchronous and active-high.
- Reset (i_rst high at an edge): state=IDLE, chunk counter=0, borrow reg=0, o_valid=0, o_d=0, o_b=0. o_ready is combinational (state==IDLE) & !i_rst, so it is 0 while i_rst is high.
- Reset mid-RUN or mid-DONE aborts the operation with no o_valid pulse. Values reset as above on the next edge.
- Arithmetic: o_d = (i_a - i_b - i_b_in) mod 2^WIDTH. o_b = 1 iff i_a < i_b + i_b_in (unsigned compare).
- The chunk counter is max(1, $clog2(NUM_CHUNKS)) bits wide.
- FSM states:
  IDLE: o_ready=1. On i_valid & o_ready at an edge: latch i_a, i_b; borrow reg<=i_b_in; counter<=0; o_d<=0; go to RUN.
  RUN: o_ready=0. Each cycle, slice k=counter goes through the CHUNK-bit subtractor with borrow-in = borrow reg. At the edge: o_d[k*CHUNK +: CHUNK] <= diff; borrow reg <= borrow-out; counter++. On slice k == NUM_CHUNKS-1: o_b <= borrow-out, o_valid <= 1, go to DONE.
  DONE: o_valid=1; o_d and o_b held stable; o_ready=0. On i_ready at an edge: o_valid<=0, go to IDLE (o_ready high the following cycle).
- Latency: o_valid rises exactly NUM_CHUNKS cycles after the accepting edge.
- Minimum spacing between accepts: NUM_CHUNKS+2 cycles. No overlap of operations; no accept in the same cycle as the output handshake.
- Inputs are ignored when o_ready=0. Changes to i_a, i_b, or i_b_in after acceptance have no effect on the result.
- o_d contents are defined only while o_valid=1. Slices fill progressively in RUN.
- NUM_CHUNKS==1 (CHUNK==WIDTH): RUN lasts one cycle; latency 1.
- i_ready high in IDLE or RUN has no effect.

Test Plan:
1. WIDTH=32, CHUNK=8: a=0x0000_0100, b=0x0000_0001, b_in=0 -> o_d=0x0000_00FF, o_b=0. o_valid exactly 4 cycles after accept, proving borrow carries from slice 0 to slice 1.
2. a=0x0000_0000, b=0x0000_0000, b_in=1 -> o_d=0xFFFF_FFFF, o_b=1 (borrow ripples through all chunks). Then a=0x8000_0000, b=0xFFFF_FFFF, b_in=0 -> o_d=0x8000_0001, o_b=1. Then a=b=0x1234_5678 -> o_d=0, o_b=0.
3. Backpressure: i_ready low for 5 cycles in DONE -> o_valid, o_d, o_b stable and o_ready=0. A concurrent i_valid with a=0xFFFF_FFFF is ignored. After i_ready is raised, o_valid falls and o_ready=1 next cycle; the next accepted op gives the correct result.
4. Reset after 2 slices of a=0x1111_1111 - 0x0000_0001 -> next cycle o_valid=0, o_d=0, o_b=0, and o_ready=0 while i_rst is high. After release, o_ready=1 and a new op 0x10 - 0x01 gives o_d=0x0000_000F with no stale slices.
5. CHUNK=WIDTH=8: a=0x05, b=0x07, b_in=0 -> o_d=0xFE, o_b=1, latency 1 cycle. Elaboration with WIDTH=30, CHUNK=8 fails.
6. Randomised back-to-back ops (i_valid always high, random i_ready) -> every result matches the reference model, accepts are spaced at least NUM_CHUNKS+2 cycles apart, and no result is dropped or duplicated.
